// File: rtl/io_cell_cfg_regs.sv
// APB register block holding shadow/active configuration for a bank of IO cells.
// Optional sticky write lock enabled by defining IOCELL_CFG_LOCK_EN.
module io_cell_cfg_regs #(
  parameter int unsigned                IOCELL_CFG_W   = 5,
  parameter int unsigned                IOCELL_COUNT   = 25,
  parameter logic [IOCELL_CFG_W-1:0]    IOCELL_CFG_RST = '0
) (
  input  logic                                 clk_in,
  input  logic                                 reset_int,
  input  logic                                 PSEL,
  input  logic                                 PENABLE,
  input  logic                                 PWRITE,
  input  logic [11:0]                          PADDR,
  input  logic [31:0]                          PWDATA,
  output logic [31:0]                          PRDATA,
  output logic                                 PREADY,
  output logic                                 PSLVERR,
  output logic [IOCELL_CFG_W*IOCELL_COUNT-1:0] cell_cfg,
  output logic                                 cfg_update
);

  localparam logic [2:0] RegionShadow = 3'b000;
  localparam logic [2:0] RegionActive = 3'b001;
  localparam logic [9:0] WordCtrl     = 10'h100;
  localparam logic [9:0] WordStatus   = 10'h101;

  logic [IOCELL_COUNT-1:0][IOCELL_CFG_W-1:0] shadow_q, shadow_d;
  logic [IOCELL_COUNT-1:0][IOCELL_CFG_W-1:0] active_q, active_d;
  logic                                      cfg_update_q, cfg_update_d;

  logic                    access;
  logic [6:0]              cell_idx;
  logic                    cell_ok;
  logic                    is_shadow, is_active, is_ctrl, is_status;
  logic                    lock;
  logic                    err;
  logic                    wr_ok, shadow_we, ctrl_we, commit;
  logic                    pending;
  logic [IOCELL_CFG_W-1:0] shadow_rd, active_rd;
  logic                    unused_bits;

  assign access    = PSEL & PENABLE;
  assign cell_idx  = PADDR[8:2];
  assign cell_ok   = 32'(cell_idx) < IOCELL_COUNT;
  assign is_shadow = (PADDR[11:9] == RegionShadow) & cell_ok;
  assign is_active = (PADDR[11:9] == RegionActive) & cell_ok;
  assign is_ctrl   = PADDR[11:2] == WordCtrl;
  assign is_status = PADDR[11:2] == WordStatus;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  // Writes are legal only to shadow cells and CTRL, and only while unlocked.
  always_comb begin
    if (PWRITE) begin
      err = !((is_shadow | is_ctrl) & !lock);
    end else begin
      err = !(is_shadow | is_active | is_status);
    end
  end

  assign wr_ok     = access & PWRITE & ~err;
  assign shadow_we = wr_ok & is_shadow;
  assign ctrl_we   = wr_ok & is_ctrl;
  assign commit    = ctrl_we & PWDATA[0];
  assign pending   = shadow_q != active_q;

  always_comb begin
    shadow_d     = shadow_q;
    active_d     = active_q;
    cfg_update_d = commit;
    for (int i = 0; i < IOCELL_COUNT; i++) begin
      if (shadow_we && (cell_idx == 7'(i))) begin
        shadow_d[i] = PWDATA[IOCELL_CFG_W-1:0];
      end
    end
    if (commit) begin
      active_d = shadow_q;
    end
  end

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      shadow_q     <= {IOCELL_COUNT{IOCELL_CFG_RST}};
      active_q     <= {IOCELL_COUNT{IOCELL_CFG_RST}};
      cfg_update_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      cfg_update_q <= cfg_update_d;
    end
  end

`ifdef IOCELL_CFG_LOCK_EN
  logic lock_q, lock_d;

  assign lock_d = lock_q | (ctrl_we & PWDATA[1]);

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      lock_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
    end
  end

  assign lock = lock_q;
`else
  assign lock = 1'b0;
`endif

  always_comb begin
    shadow_rd = '0;
    active_rd = '0;
    for (int i = 0; i < IOCELL_COUNT; i++) begin
      if (cell_idx == 7'(i)) begin
        shadow_rd = shadow_q[i];
        active_rd = active_q[i];
      end
    end
  end

  // Bus outputs are combinational and forced low while reset is held.
  always_comb begin
    PRDATA = '0;
    if (reset_int && access && !PWRITE && !err) begin
      if (is_shadow) begin
        PRDATA[IOCELL_CFG_W-1:0] = shadow_rd;
      end else if (is_active) begin
        PRDATA[IOCELL_CFG_W-1:0] = active_rd;
      end else if (is_status) begin
        PRDATA[1:0] = {lock, pending};
      end
    end
  end

  assign PREADY     = access & reset_int;
  assign PSLVERR    = access & reset_int & err;
  assign cell_cfg   = active_q;
  assign cfg_update = cfg_update_q;

endmodule
